// File: rtl/hd_demux2_buf_if.sv
// ----------------------------------------------------------------------------
// hd_demux2_buf_if
// Bundle of the producer-side and consumer-side handshake signals of
// hd_demux2_buf.
//   A/SL/AV/AR       : input word, destination select, valid, ready
//   Z0/Z0V/Z0R/OCC0  : channel 0 head data, valid, ready, occupancy
//   Z1/Z1V/Z1R/OCC1  : channel 1 head data, valid, ready, occupancy
// Modports:
//   slave  : the demultiplexer itself
//   master : the environment (producer plus both consumers)
// ----------------------------------------------------------------------------
interface hd_demux2_buf_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic [WIDTH-1:0] A;
    logic             SL;
    logic             AV;
    logic             AR;
    logic [WIDTH-1:0] Z0;
    logic             Z0V;
    logic             Z0R;
    logic [WIDTH-1:0] Z1;
    logic             Z1V;
    logic             Z1R;
    logic [CW-1:0]    OCC0;
    logic [CW-1:0]    OCC1;

    modport slave (
        input  A, SL, AV, Z0R, Z1R,
        output AR, Z0, Z0V, Z1, Z1V, OCC0, OCC1
    );

    modport master (
        output A, SL, AV, Z0R, Z1R,
        input  AR, Z0, Z0V, Z1, Z1V, OCC0, OCC1
    );
endinterface

// File: rtl/hd_demux2_buf.sv
// ----------------------------------------------------------------------------
// hd_demux2_buf
// Buffered 1-to-2 stream demultiplexer. Each word on A is steered to channel
// SL (0 or 1); each channel owns a DEPTH-entry FIFO with a valid/ready output.
// Heads are read from registered storage, so there is no path from A to Zn.
// Ports:
//   CP  : clock, rising edge
//   CD  : asynchronous active-high clear; discards all buffered words
//   bus : hd_demux2_buf_if.slave (A, SL, AV, AR, Zn, ZnV, ZnR, OCCn)
// Build option:
//   HD_DEMUX2_RR_EN : ignore SL and alternate destinations with an internal
//                     round-robin bit that toggles on every accepted word.
// ----------------------------------------------------------------------------
module hd_demux2_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic            CP,
    input logic            CD,
    hd_demux2_buf_if.slave bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [2][DEPTH];
    logic [PW-1:0]    r_wp  [2];
    logic [PW-1:0]    r_rp  [2];
    logic [CW-1:0]    r_cnt [2];

    logic [1:0] w_full;
    logic [1:0] w_empty;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_rdy;
    logic       w_dst;
    logic       w_sel_x;
    logic       w_accept;

`ifdef HD_DEMUX2_RR_EN
    logic r_rr;

    // A stall on the full channel holds rr; it only advances on an accept.
    always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
            r_rr <= 1'b0;
        end else if (w_accept) begin
            r_rr <= ~r_rr;
        end
    end

    assign w_dst   = r_rr;
    assign w_sel_x = 1'b0;
`else
    assign w_dst = bus.SL;
`ifndef SYNTHESIS
    // An unknown select must not write anywhere.
    assign w_sel_x = $isunknown(bus.SL);
`else
    assign w_sel_x = 1'b0;
`endif
`endif

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_full[c]  = (r_cnt[c] == FULL_CNT);
            w_empty[c] = (r_cnt[c] == '0);
        end
    end

    assign w_rdy = {bus.Z1R, bus.Z0R};

    // Full blocks the channel outright, so a pop cannot make room for a push
    // in the same cycle.
    assign bus.AR   = !CD && !w_sel_x && !w_full[w_dst];
    assign w_accept = bus.AV && bus.AR;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_push[c] = w_accept && (w_dst == 1'(c));
            w_pop[c]  = !w_empty[c] && w_rdy[c];
        end
    end

    always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
            for (int c = 0; c < 2; c++) begin
                r_wp[c]  <= '0;
                r_rp[c]  <= '0;
                r_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_push[c]) begin
                    r_wp[c] <= r_wp[c] + PW'(1);
                end
                if (w_pop[c]) begin
                    r_rp[c] <= r_rp[c] + PW'(1);
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + CW'(1);
                    2'b01:   r_cnt[c] <= r_cnt[c] - CW'(1);
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
        end
    end

    // Storage needs no clear: stale entries are never visible because the
    // heads are masked while a channel is empty.
    always_ff @(posedge CP) begin
        for (int c = 0; c < 2; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wp[c]] <= bus.A;
            end
        end
    end

    assign bus.Z0   = w_empty[0] ? '0 : r_mem[0][r_rp[0]];
    assign bus.Z1   = w_empty[1] ? '0 : r_mem[1][r_rp[1]];
    assign bus.Z0V  = !w_empty[0];
    assign bus.Z1V  = !w_empty[1];
    assign bus.OCC0 = r_cnt[0];
    assign bus.OCC1 = r_cnt[1];

`ifndef SYNTHESIS
    always @(posedge CP) begin
        if (!CD) begin
            for (int c = 0; c < 2; c++) begin
                assert (r_cnt[c] <= FULL_CNT)
                else $error("hd_demux2_buf: occupancy above DEPTH on channel %0d", c);
                assert (!(w_push[c] && w_full[c]))
                else $error("hd_demux2_buf: push to full channel %0d", c);
                assert (!(w_pop[c] && w_empty[c]))
                else $error("hd_demux2_buf: pop from empty channel %0d", c);
            end
        end
    end
`endif
endmodule

// File: tb/tb_hd_demux2_buf.sv
module tb_hd_demux2_buf;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic CP;
    logic CD;

    hd_demux2_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    hd_demux2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CP  (CP),
        .CD  (CD),
        .bus (bus)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Scoreboard: expected words per channel plus a model occupancy.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               m_occ0;
    int               m_occ1;
    logic             m_rr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        m_occ0 = 0;
        m_occ1 = 0;
        m_rr   = 1'b0;
    endfunction

    // One clock: compare outputs against the model at the falling edge, apply
    // the handshakes the model predicts, then step to just past the rising edge.
    task automatic cycle();
        logic dst;
        logic dst_x;
        logic exp_ar;
        logic acc;
        logic pop0;
        logic pop1;
        @(negedge CP);
        if (CD) begin
            check_eq("rst_ar", bus.AR, 1'b0);
            check_eq("rst_z0v", bus.Z0V, 1'b0);
            check_eq("rst_z1v", bus.Z1V, 1'b0);
            check_eq("rst_occ0", bus.OCC0, 0);
            check_eq("rst_occ1", bus.OCC1, 0);
            check_eq("rst_z0", bus.Z0, 0);
            check_eq("rst_z1", bus.Z1, 0);
            model_reset();
        end else begin
`ifdef HD_DEMUX2_RR_EN
            dst   = m_rr;
            dst_x = 1'b0;
`else
            dst   = bus.SL;
            dst_x = $isunknown(bus.SL);
`endif
            if (dst_x) exp_ar = 1'b0;
            else exp_ar = dst ? (m_occ1 != DEPTH) : (m_occ0 != DEPTH);
            check_eq("occ0", bus.OCC0, m_occ0);
            check_eq("occ1", bus.OCC1, m_occ1);
            check_eq("z0v", bus.Z0V, m_occ0 != 0);
            check_eq("z1v", bus.Z1V, m_occ1 != 0);
            if (m_occ0 != 0) check_eq("z0", bus.Z0, q0[0]);
            if (m_occ1 != 0) check_eq("z1", bus.Z1, q1[0]);
            check_eq("ar", bus.AR, exp_ar);
            acc  = bus.AV && exp_ar;
            pop0 = (m_occ0 != 0) && bus.Z0R;
            pop1 = (m_occ1 != 0) && bus.Z1R;
            if (pop0) begin
                void'(q0.pop_front());
                m_occ0--;
            end
            if (pop1) begin
                void'(q1.pop_front());
                m_occ1--;
            end
            if (acc) begin
                if (dst) begin
                    q1.push_back(bus.A);
                    m_occ1++;
                end else begin
                    q0.push_back(bus.A);
                    m_occ0++;
                end
                m_rr = ~m_rr;
            end
        end
        @(posedge CP);
        #1;
    endtask

    task automatic drive(input logic av, input logic sl, input logic [WIDTH-1:0] a,
                         input logic r0, input logic r1);
        bus.AV  = av;
        bus.SL  = sl;
        bus.A   = a;
        bus.Z0R = r0;
        bus.Z1R = r1;
        cycle();
    endtask

    initial begin
        model_reset();
        CD = 1'b1;
        bus.AV = 1'b1; bus.SL = 1'b0; bus.A = '0; bus.Z0R = 1'b0; bus.Z1R = 1'b0;

        // Clear held with AV=1: everything reads zero, AR=0.
        cycle();
        cycle();
        CD = 1'b0;

        // First word after clear, one-cycle latency to channel 1.
        drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Fill channel 0, stall on it, route to channel 1, then drain in order.
        drive(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push/pop on channel 0 across pointer wrap.
        drive(1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 8'h10 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Randomised traffic: blocking, cross-channel independence, back-pressure.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Load channels, then clear asynchronously between edges.
        drive(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1 CD = 1'b1;
        #1;
        check_eq("mid_z0v", bus.Z0V, 1'b0);
        check_eq("mid_z1v", bus.Z1V, 1'b0);
        check_eq("mid_occ0", bus.OCC0, 0);
        check_eq("mid_occ1", bus.OCC1, 0);
        check_eq("mid_ar", bus.AR, 1'b0);
        #1 CD = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h88, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Unknown select with AV held.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'bx, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

`ifdef HD_DEMUX2_RR_EN
        // Alternation with SL held at 0, then a stall on the full channel.
        CD = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        CD = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hA4, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hA6, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hA7, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hd_demux2_buf.md
Name: hd_demux2_buf

Overview:
- Buffered 1-to-2 stream demultiplexer, the sequential counterpart to the 2:1 select cell.
- One input word on A is steered by SL to output channel 0 or channel 1.
- Each channel has its own DEPTH-entry FIFO and a valid/ready handshake.
- Sits between a single producer and two independent consumers in the std-cell model library; the outputs are registered.

Parameters:
- WIDTH, 8, data width of A, Z0 and Z1.
- DEPTH, 2, entries per channel FIFO; a power of two, at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy outputs.

Ports:
- CP  input  1  clock, rising edge.
- CD  input  1  clear; asynchronous, active-high.
- A  input  WIDTH  input data.
- SL  input  1  destination select: 0 selects channel 0, 1 selects channel 1. Sampled together with A.
- AV  input  1  input valid.
- AR  output  1  input ready.
- Z0  output  WIDTH  channel 0 head data.
- Z0V  output  1  channel 0 valid.
- Z0R  input  1  channel 0 ready from the consumer.
- Z1  output  WIDTH  channel 1 head data.
- Z1V  output  1  channel 1 valid.
- Z1R  input  1  channel 1 ready from the consumer.
- OCC0  output  CW  channel 0 occupancy, range 0..DEPTH.
- OCC1  output  CW  channel 1 occupancy, range 0..DEPTH.

Behaviour:
- Clock and reset: one clock, CP. CD is asynchronous and active-high. While CD=1:
  - all read/write pointers and counts are 0;
  - Z0V=Z1V=0, Z0=Z1=0, OCC0=OCC1=0;
  - AR=0.
  - A CD assertion mid-transfer discards all buffered words; no partial word survives.
  - First accept is possible on the first CP rising edge after CD falls.
- Destination: dst = SL. (In round-robin mode, see Optional Feature, dst is the rr bit.)
- Input acceptance:
  - AR = !full[dst], computed combinationally from SL and the current occupancy.
  - A transfer occurs on a rising CP edge when AV && AR. The word is written to the tail of FIFO[dst]; OCC[dst] increments.
  - No pass-through when full: a pop and a push to the same full channel in the same cycle is not allowed; AR=0 in that cycle.
- X handling (simulation): if AV=1 and SL is X or Z, AR=0 and nothing is written, matching the select cell's X-reduction intent.
- Output side, per channel n:
  - ZnV = (OCCn != 0).
  - Zn = FIFO head, driven from registered storage; no combinational path from A.
  - A pop occurs on the edge where ZnV && ZnR; the read pointer advances and OCCn decrements.
- Latency: a word accepted at edge k is visible on Zn with ZnV=1 after edge k, when its channel was empty. Minimum latency is 1 cycle.
- Simultaneous push and pop on the same non-full, non-empty channel: OCC is unchanged and both pointers advance.
- Push to one channel and pop from the other in the same edge: the two are independent.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is OCC==DEPTH; empty is OCC==0.
- Ordering: per-channel FIFO order is preserved. No ordering is defined across channels.
- Blocking: a full channel blocks only inputs addressed to it. While the producer holds AV with SL pointing at the full channel, the other channel still drains.
- Assertions (simulation only):
  - OCCn never exceeds DEPTH;
  - no push to a full channel;
  - no pop from an empty channel.

Optional Feature:
- Macro: HD_DEMUX2_RR_EN.
- When defined:
  - SL is ignored and dst = rr, an internal register reset to 0 by CD.
  - rr toggles after every accepted input transfer.
  - AR = !full[rr]. A stall on the full channel holds rr; it does not skip to the other channel.
  - The X check on SL is removed.
- When undefined: there is no rr register and dst = SL exactly as described above.

Test Plan:
- Reset: drive CD=1 with AV=1 -> AR=0, Z0V=Z1V=0, OCC0=OCC1=0. Release CD; push A=8'h5A, SL=1 -> after 1 edge Z1=8'h5A, Z1V=1, Z0V=0, OCC1=1.
- Fill: DEPTH=2, Z0R=0; push 8'h01 then 8'h02 with SL=0 -> OCC0=2 and AR=0 while SL=0. With SL=1, AR=1 and 8'h03 lands in channel 1. Then Z0R=1 -> Z0 shows 8'h01 then 8'h02 in order.
- Simultaneous events: with OCC0=1, push and pop on channel 0 in the same edge -> OCC0 stays 1 and the new word becomes head on the next cycle. Repeat for 8 cycles to exercise pointer wrap -> output order equals input order.
- Reset mid-operation: with OCC0=2 and OCC1=1, pulse CD asynchronously between edges -> Z0V and Z1V drop immediately and OCC0=OCC1=0. Subsequent data are unaffected by the discarded words.
- X select: AV=1, SL=1'bx -> AR=0 and OCC0/OCC1 unchanged across 3 edges.
- HD_DEMUX2_RR_EN build: push 8'hA0..8'hA3 with SL held at 0 -> channel 0 receives A0, A2 and channel 1 receives A1, A3. With channel 1 full, AR=0 on the rr=1 cycle and rr holds until a channel 1 pop.
